enigma_rotor_sequencer: RTL

Per-character sequencing controller for the Enigma letter datapath. It accepts one uppercase ASCII letter at a time over a valid/ready handshake and steps three rotor position counters odometer-style. It then pushes the letter through three add-and-wrap stages, one per rotor offset, and returns the enciphered or deciphered letter over a second valid/ready handshake. Each wrap decision uses the letter-overflow comparison rule: a non-truncated value above 'Z' (90) has 26 subtracted, and one below 'A' (65) has 26 added.

---
 rtl/enigma_rotor_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/enigma_rotor_sequencer.sv
// Per-character Enigma sequencer: odometer-steps three rotor positions, then runs
// the accepted letter through three add-and-wrap stages, one per rotor offset.
module enigma_rotor_sequencer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_char_in,
    input  logic        i_char_valid,
    output logic        o_char_ready,
    input  logic        i_decrypt,
    input  logic        i_load_pos,
    input  logic [14:0] i_pos_in,
    output logic [7:0]  o_char_out,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [14:0] o_rotor_pos
);

    typedef enum logic [3:0] {
        S_IDLE, S_STEP, S_ADD0, S_FIX0, S_ADD1, S_FIX1, S_ADD2, S_FIX2, S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_p0;
    logic [4:0] r_p1;
    logic [4:0] r_p2;
    logic [7:0] r_v;
    logic [7:0] r_char_out;
    logic       r_dec;
    logic       w_is_letter;
    logic [4:0] w_off;
    logic [7:0] w_sum;
    logic [7:0] w_fix;

    function automatic logic [4:0] clamp26(input logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] p);
        return (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    assign w_is_letter = (i_char_in >= 8'd65) && (i_char_in <= 8'd90);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!i_load_pos && i_char_valid)
                    w_next = w_is_letter ? S_STEP : S_DONE;
            end
            S_STEP:  w_next = S_ADD0;
            S_ADD0:  w_next = S_FIX0;
            S_FIX0:  w_next = S_ADD1;
            S_ADD1:  w_next = S_FIX1;
            S_FIX1:  w_next = S_ADD2;
            S_ADD2:  w_next = S_FIX2;
            S_FIX2:  w_next = S_DONE;
            S_DONE: begin
                if (i_out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Offsets are read after STEP, so each stage uses the post-step rotor position.
    always_comb begin
        w_off = '0;
        case (r_state)
            S_ADD0:  w_off = r_p0;
            S_ADD1:  w_off = r_p1;
            S_ADD2:  w_off = r_p2;
            default: w_off = '0;
        endcase
    end

    assign w_sum = r_dec ? (r_v - {3'b000, w_off}) : (r_v + {3'b000, w_off});

    always_comb begin
        w_fix = r_v;
        if (r_dec) begin
            if (r_v < 8'd65)
                w_fix = r_v + 8'd26;
        end else begin
            if (r_v > 8'd90)
                w_fix = r_v - 8'd26;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_p0       <= '0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_v        <= '0;
            r_dec      <= 1'b0;
            r_char_out <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_load_pos) begin
                        r_p0 <= clamp26(i_pos_in[4:0]);
                        r_p1 <= clamp26(i_pos_in[9:5]);
                        r_p2 <= clamp26(i_pos_in[14:10]);
                    end else if (i_char_valid) begin
                        r_v   <= i_char_in;
                        r_dec <= i_decrypt;
                        if (!w_is_letter)
                            r_char_out <= i_char_in;
                    end
                end
                S_STEP: begin
                    r_p0 <= inc26(r_p0);
                    if (r_p0 == 5'd25) begin
                        r_p1 <= inc26(r_p1);
                        if (r_p1 == 5'd25)
                            r_p2 <= inc26(r_p2);
                    end
                end
                S_ADD0, S_ADD1, S_ADD2: r_v <= w_sum;
                S_FIX0, S_FIX1:         r_v <= w_fix;
                S_FIX2: begin
                    r_v        <= w_fix;
                    r_char_out <= w_fix;
                end
                default: ;
            endcase
        end
    end

    assign o_char_ready = (r_state == S_IDLE) && !i_load_pos;
    assign o_out_valid  = (r_state == S_DONE);
    assign o_char_out   = r_char_out;
    assign o_rotor_pos  = {r_p2, r_p1, r_p0};

endmodule
